// File: rtl/mux4a1_rr_arb.sv
// mux4a1_rr_arb: round-robin arbiter for a shared 4:1 mux with registered select and valid-qualified data
module mux4a1_rr_arb #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] D,
  output logic [3:0] gnt,
  output logic       Sa1,
  output logic       Sa0,
  output logic       Ya,
  output logic       Yv,
  output logic       busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d, owner_q, owner_d, sel_q, sel_d, start, win;
  logic [7:0] hold_q, hold_d;
  logic [3:0] gnt_q, gnt_d, others, cand;
  logic       ya_q, ya_d, yv_q, yv_d, rel, pre, arb, found;
  always_comb begin
    others = req & ~(4'b0001 << owner_q);
    rel = !req[owner_q];
    pre = hold_q == 8'(MAX_HOLD) && |others;
    // a handover re-arbitrates from owner+1, which is the updated ptr
    start = state_q == GRANT ? owner_q + 2'd1 : ptr_q;
    cand = state_q == GRANT && pre ? others : req;
    found = 1'b0;
    win = start;
    for (int k = 3; k >= 0; k--) begin
      if (cand[start + 2'(k)]) begin
        found = 1'b1;
        win = start + 2'(k);
      end
    end
    arb = state_q == IDLE || rel || pre;
    state_d = arb ? (found ? GRANT : IDLE) : state_q;
    owner_d = arb && found ? win : owner_q;
    ptr_d = state_q == GRANT && (rel || pre) ? owner_q + 2'd1 : ptr_q;
    hold_d = arb && found ? 8'd1 : (!arb && hold_q != 8'hff ? hold_q + 8'd1 : hold_q);
    gnt_d = state_d == GRANT ? 4'b0001 << owner_d : 4'b0000;
    sel_d = state_d == GRANT ? owner_d : sel_q;
    ya_d = state_q == GRANT ? D[owner_q] : ya_q;
    yv_d = state_q == GRANT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      ya_q    <= 1'b0;
      yv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ya_q    <= ya_d;
      yv_q    <= yv_d;
    end
  end
  assign gnt = gnt_q;
  assign {Sa1, Sa0} = sel_q;
  assign Ya = ya_q;
  assign Yv = yv_q;
  assign busy = state_q == GRANT;
endmodule

// File: tb/tb_mux4a1_rr_arb.sv
// tb_mux4a1_rr_arb: scoreboard bench with a queue-fed monitor and an integer-level arbitration model
module tb_mux4a1_rr_arb;
  localparam int MAX_HOLD = 4;
  logic       clk = 1'b0, rst;
  logic [3:0] req, D, gnt;
  logic       Sa1, Sa0, Ya, Yv, busy;
  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic       ya;
    logic       yv;
    logic       b;
  } exp_t;
  exp_t q[$];
  int   n_cmp = 0, n_err = 0;
  bit   m_busy;
  int   m_owner, m_ptr, m_hold;
  logic [1:0] m_sel;
  logic       m_ya;

  mux4a1_rr_arb #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .D(D), .gnt(gnt),
    .Sa1(Sa1), .Sa0(Sa0), .Ya(Ya), .Yv(Yv), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int first_req(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++) if (m[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_sel = 2'd0; m_ya = 1'b0;
    q.delete();
  endtask

  task automatic cyc(input logic [3:0] r, input logic [3:0] d);
    exp_t e;
    logic [3:0] mask;
    int w;
    bit prev_busy;
    @(negedge clk);
    req = r;
    D = d;
    prev_busy = m_busy;
    if (m_busy) m_ya = d[m_owner];
    if (!m_busy) begin
      w = first_req(r, m_ptr);
      if (w >= 0) begin m_busy = 1; m_owner = w; m_hold = 1; end
    end else begin
      mask = r;
      mask[m_owner] = 1'b0;
      if (!r[m_owner] || (m_hold == MAX_HOLD && mask != 0)) begin
        m_ptr = (m_owner + 1) % 4;
        w = first_req(mask, m_ptr);
        if (w >= 0) begin m_owner = w; m_hold = 1; end
        else m_busy = 0;
      end else m_hold = m_hold < 255 ? m_hold + 1 : 255;
    end
    if (m_busy) m_sel = 2'(m_owner);
    e.g = m_busy ? 4'(1 << m_owner) : 4'd0;
    e.s = m_sel;
    e.ya = m_ya;
    e.yv = prev_busy;
    e.b = m_busy;
    q.push_back(e);
  endtask

  task automatic chk_rst(input string name);
    n_cmp++;
    if ({gnt, Sa1, Sa0, Ya, Yv, busy} !== 9'd0) begin
      n_err++;
      $display("FAIL %s: gnt=%b Sa=%b%b Ya=%b Yv=%b busy=%b, required all zero",
               name, gnt, Sa1, Sa0, Ya, Yv, busy);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if ({gnt, Sa1, Sa0, Ya, Yv, busy} !== e) begin
        n_err++;
        $display("FAIL cycle@%0t: got gnt=%b Sa=%b%b Ya=%b Yv=%b busy=%b, required gnt=%b Sa=%b Ya=%b Yv=%b busy=%b",
                 $time, gnt, Sa1, Sa0, Ya, Yv, busy, e.g, e.s, e.ya, e.yv, e.b);
      end
    end
  end

  initial begin
    logic [3:0] r;
    rst = 1'b1; req = 4'd0; D = 4'd0;
    model_reset();
    #1 chk_rst("reset_values");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (3) cyc(4'b0000, 4'b0000);
    repeat (3) cyc(4'b0001, 4'b1001);
    repeat (3) cyc(4'b0000, 4'b1001);
    repeat (24) cyc(4'b1111, 4'b1001);
    repeat (3) cyc(4'b0000, 4'b1001);
    cyc(4'b1000, 4'b1010);
    cyc(4'b1001, 4'b0011);
    repeat (3) cyc(4'b0001, 4'b0101);
    repeat (2) cyc(4'b0000, 4'b0000);
    repeat (20) cyc(4'b0100, 4'($urandom));
    repeat (2) cyc(4'b0000, 4'b0000);
    repeat (2) cyc(4'b0010, 4'b0010);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_rst("reset_mid_grant");
    model_reset();
    req = 4'b1111;
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (6) cyc(4'b1111, 4'b0110);
    r = 4'd0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) r = 4'($urandom);
      cyc(r, 4'($urandom));
    end
    repeat (3) cyc(4'b0000, 4'b0000);
    @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
